// File: rtl/uart_word_packer.sv
// Packs little-endian UART bytes into 32-bit words and writes them into a memory ring through a
// single enable/done arbitration port, publishing the ring write pointer.
module uart_word_packer #(
  parameter logic [14:0] BASE_ADDR      = 15'h0000,
  parameter int unsigned DEPTH_LOG2     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  input  logic [DEPTH_LOG2-1:0] rd_ptr,
  input  logic                  mem_done,
  output logic                  mem_enable,
  output logic                  mem_readWrite,
  output logic [14:0]           mem_address,
  output logic [31:0]           mem_DataWrite,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic                  overflow,
  output logic                  frame_error
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [31:0]           pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                  overflow_q, overflow_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  word_done, timeout_hit, moving, ring_full, accept;
  logic [DEPTH_LOG2-1:0] occ;

  always_comb begin
    word_done   = rx_valid && (byte_cnt_q == 2'd3);
    timeout_hit = (byte_cnt_q != 2'd0) && !rx_valid && (tmo_q == TMAX);
    // Pending is handed to the write stage this edge, so a new word may take its place.
    moving      = (state_q == StIdle) && pend_valid_q;
    // Slots already claimed: committed ones plus the word in flight and the one pending.
    occ         = wr_ptr_q + DEPTH_LOG2'(state_q == StWrite) + DEPTH_LOG2'(pend_valid_q);
    ring_full   = (occ + DEPTH_LOG2'(1)) == rd_ptr;
    accept      = word_done && (!pend_valid_q || moving) && !ring_full;
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    wdata_d      = wdata_q;
    wr_ptr_d     = wr_ptr_q;
    overflow_d   = overflow_q;
    tmo_d        = tmo_q;

    if (rx_valid) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      tmo_d      = '0;
      case (byte_cnt_q)
        2'd0:    shift_d[7:0]   = rx_byte;
        2'd1:    shift_d[15:8]  = rx_byte;
        2'd2:    shift_d[23:16] = rx_byte;
        default: shift_d        = '0;
      endcase
    end else if (byte_cnt_q != 2'd0) begin
      if (timeout_hit) begin
        byte_cnt_d = '0;
        shift_d    = '0;
        tmo_d      = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          wdata_d      = pend_q;
          pend_valid_d = 1'b0;
          state_d      = StWrite;
        end
      end
      StWrite: begin
        if (mem_done) begin
          wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      pend_d       = {rx_byte, shift_q};
      pend_valid_d = 1'b1;
    end else if (word_done) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      wdata_q      <= '0;
      wr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      wdata_q      <= wdata_d;
      wr_ptr_q     <= wr_ptr_d;
      overflow_q   <= overflow_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    mem_enable    = (state_q == StWrite);
    mem_readWrite = mem_enable;
    mem_address   = mem_enable ? (BASE_ADDR + 15'(wr_ptr_q)) : 15'h0000;
    mem_DataWrite = mem_enable ? wdata_q : 32'h0;
    wr_ptr        = wr_ptr_q;
    overflow      = overflow_q;
    frame_error   = timeout_hit;
  end

endmodule

// File: tb/tb_uart_word_packer.sv
// Scoreboard bench: stimulus pushes expected ring writes, a separate arbiter/monitor process
// acknowledges memory requests and checks them against the queue in order.
module tb_uart_word_packer;

  localparam logic [14:0] BASE = 15'h0120;
  localparam int unsigned DL2  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rx_byte = 8'h00;
  logic            rx_valid = 1'b0;
  logic [DL2-1:0]  rd_ptr = '0;
  logic            mem_done;
  logic            mem_enable, mem_readWrite, overflow, frame_error;
  logic [14:0]     mem_address;
  logic [31:0]     mem_DataWrite;
  logic [DL2-1:0]  wr_ptr;

  logic arb_done = 1'b0;
  logic tb_done  = 1'b0;
  logic arb_en   = 1'b1;
  int   done_delay = 3;
  assign mem_done = arb_done | tb_done;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb_q[$];

  int tests = 0;
  int fails = 0;

  uart_word_packer #(
    .BASE_ADDR     (BASE),
    .DEPTH_LOG2    (DL2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rd_ptr       (rd_ptr),
    .mem_done     (mem_done),
    .mem_enable   (mem_enable),
    .mem_readWrite(mem_readWrite),
    .mem_address  (mem_address),
    .mem_DataWrite(mem_DataWrite),
    .wr_ptr       (wr_ptr),
    .overflow     (overflow),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Arbiter model and monitor
  always begin
    @(negedge clk);
    if (arb_en && mem_enable) begin
      logic [14:0] a;
      logic [31:0] d;
      logic        stable;
      wr_t         e;
      a = mem_address;
      d = mem_DataWrite;
      stable = mem_readWrite;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", a, d);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", {17'h0, a}, {17'h0, e.addr});
        chk("wr_data", d, e.data);
      end
      for (int i = 0; i < done_delay; i++) begin
        @(negedge clk);
        if (!mem_enable || !mem_readWrite || mem_address != a || mem_DataWrite != d) stable = 1'b0;
      end
      arb_done = 1'b1;
      @(negedge clk);
      arb_done = 1'b0;
      chk("wr_stable", {31'h0, stable}, 32'h1);
      chk("enable_fall", {31'h0, mem_enable}, 32'h0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_ptr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_wr, input int slot);
    if (expect_wr) sb_q.push_back({BASE + 15'(slot), w});
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((sb_q.size() != 0 || mem_enable) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_time", {31'h0, n < limit}, 32'h1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int fe_idx;
    int fe_cnt;
    logic quiet;

    // Reset state
    do_reset();
    chk("rst_enable", {31'h0, mem_enable}, 32'h0);
    chk("rst_rw", {31'h0, mem_readWrite}, 32'h0);
    chk("rst_addr", {17'h0, mem_address}, 32'h0);
    chk("rst_data", mem_DataWrite, 32'h0);
    chk("rst_wrptr", {30'h0, wr_ptr}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_fe", {31'h0, frame_error}, 32'h0);

    // 1: single word, latency, done after 3 cycles
    done_delay = 3;
    send_word(32'h4433_2211, 1'b1, 0);
    chk("lat_n1_low", {31'h0, mem_enable}, 32'h0);
    @(negedge clk);
    chk("lat_n2_high", {31'h0, mem_enable}, 32'h1);
    wait_idle(200);
    chk("t1_wrptr", {30'h0, wr_ptr}, 32'h1);
    chk("t1_ovf", {31'h0, overflow}, 32'h0);

    // 2: arbiter stalls 20 cycles; pointer advances once
    do_reset();
    done_delay = 20;
    send_word(32'hCAFE_F00D, 1'b1, 0);
    wait_idle(200);
    chk("t2_wrptr", {30'h0, wr_ptr}, 32'h1);

    // 3: ring capacity DEPTH-1, drop on full, then wrap
    do_reset();
    done_delay = 2;
    for (int i = 0; i < 3; i++) begin
      send_word(32'h1000_0000 + 32'(i), 1'b1, i);
      wait_idle(200);
    end
    chk("t3_wrptr3", {30'h0, wr_ptr}, 32'h3);
    chk("t3_ovf0", {31'h0, overflow}, 32'h0);
    send_word(32'h1000_0003, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("t3_ovf1", {31'h0, overflow}, 32'h1);
    chk("t3_nowrite", {31'h0, mem_enable}, 32'h0);
    chk("t3_wrptr_hold", {30'h0, wr_ptr}, 32'h3);
    rd_ptr = 2'd1;
    send_word(32'h1000_0004, 1'b1, 3);
    wait_idle(200);
    chk("t3_wrap", {30'h0, wr_ptr}, 32'h0);

    // 4: partial-word timeout, then a clean word
    do_reset();
    done_delay = 3;
    send_byte(8'h01);
    send_byte(8'h02);
    fe_idx = -1;
    fe_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      if (frame_error) begin
        fe_cnt++;
        fe_idx = i;
      end
    end
    chk("t4_fe_pos", 32'(fe_idx), 32'd15);
    chk("t4_fe_cnt", 32'(fe_cnt), 32'd1);
    send_word(32'hDDCC_BBAA, 1'b1, 0);
    wait_idle(200);
    chk("t4_wrptr", {30'h0, wr_ptr}, 32'h1);

    // 5: reset while a write is in flight, late done ignored
    do_reset();
    arb_en = 1'b0;
    send_word(32'h5555_0001, 1'b0, 0);
    send_word(32'h5555_0002, 1'b0, 0);
    send_word(32'h5555_0003, 1'b0, 0);
    chk("t5_busy", {31'h0, mem_enable}, 32'h1);
    chk("t5_ovf_pre", {31'h0, overflow}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_enable", {31'h0, mem_enable}, 32'h0);
    chk("t5_wrptr", {30'h0, wr_ptr}, 32'h0);
    chk("t5_ovf", {31'h0, overflow}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (mem_enable) quiet = 1'b0;
    end
    chk("t5_quiet", {31'h0, quiet}, 32'h1);
    chk("t5_wrptr_late", {30'h0, wr_ptr}, 32'h0);
    arb_en = 1'b1;

    // 6: long stall, second word pending, third dropped
    do_reset();
    done_delay = 200;
    send_word(32'h6666_0001, 1'b1, 0);
    send_word(32'h6666_0002, 1'b1, 1);
    send_word(32'h6666_0003, 1'b0, 0);
    chk("t6_ovf", {31'h0, overflow}, 32'h1);
    wait_idle(1000);
    chk("t6_wrptr", {30'h0, wr_ptr}, 32'h2);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
